// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped, write-through cache.
package cache_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_MEM  = 2'd2,
        ST_REFILL  = 2'd3
    } state_e;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 2;
    localparam int INDEX_W    = 5;
    localparam int CNT_W      = 16;

    // Saturating increment for the statistics counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for the cache lines. Reads are combinational for the
// addressed line; writes are synchronous, either a whole line (refill, which
// also sets the tag and valid bit) or a single word (write hit).
module cache_line_store
    import cache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LINES = 32,
    parameter int TAG_W = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [INDEX_W-1:0]          index,
    input  logic [OFFSET_W-1:0]         offset,
    output logic                        rd_valid,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [WIDTH-1:0]            rd_word,
    input  logic                        line_we,
    input  logic [TAG_W-1:0]            line_tag,
    input  logic [LINE_WORDS*WIDTH-1:0] line_data,
    input  logic                        word_we,
    input  logic [WIDTH-1:0]            word_data
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [WIDTH-1:0] data_q [LINES][LINE_WORDS];

    // Combinational read of the addressed line
    always_comb begin
        rd_valid = valid_q[index];
        rd_tag   = tag_q[index];
        rd_word  = data_q[index][offset];
    end

    // Valid bits are the only state cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag and data writes; a refill takes priority over a single-word update
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[index] <= line_tag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                data_q[index][k] <= line_data[k*WIDTH +: WIDTH];
            end
        end else if (word_we) begin
            data_q[index][offset] <= word_data;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Handshake: in IDLE a request is taken on the edge where cpu_read/cpu_write is
// high; cpu_stall then stays high until the request completes, and the CPU keeps
// its request inputs stable meanwhile. Memory completion is mem_ready=1, which is
// only honoured from the second cycle of RD_MISS / WR_MEM onwards.
module cache_controller
    import cache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int LINES = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AW-1:0]               cpu_addr,
    input  logic                        cpu_read,
    input  logic                        cpu_write,
    input  logic [WIDTH-1:0]            cpu_wdata,
    output logic [WIDTH-1:0]            cpu_rdata,
    output logic                        cpu_stall,
    output logic [AW-1:0]               mem_addr,
    output logic                        mem_read_en,
    output logic                        mem_write_en,
    output logic [WIDTH-1:0]            mem_wdata,
    input  logic                        mem_ready,
    input  logic [LINE_WORDS*WIDTH-1:0] mem_rdata,
    output logic [CNT_W-1:0]            hit_count,
    output logic [CNT_W-1:0]            miss_count,
    output state_e                      dbg_state
);

    localparam int TAG_W = AW - OFFSET_W - INDEX_W;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [WIDTH-1:0]    rd_word;
    logic                hit;
    logic                line_we;
    logic                word_we;

    state_e              state_q, state_d;
    logic                first_q, first_d;
    logic                cpu_stall_q, cpu_stall_d;
    logic                mem_read_en_q, mem_read_en_d;
    logic                mem_write_en_q, mem_write_en_d;
    logic [WIDTH-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [CNT_W-1:0]    miss_count_q, miss_count_d;

    assign addr_tag    = cpu_addr[AW-1:OFFSET_W+INDEX_W];
    assign addr_index  = cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign addr_offset = cpu_addr[OFFSET_W-1:0];
    assign hit         = rd_valid && (rd_tag == addr_tag);

    cache_line_store #(
        .WIDTH (WIDTH),
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .index     (addr_index),
        .offset    (addr_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .line_we   (line_we),
        .line_tag  (addr_tag),
        .line_data (mem_rdata),
        .word_we   (word_we),
        .word_data (cpu_wdata)
    );

    // Next-state and next-output logic for the FSM and counters
    always_comb begin
        state_d        = state_q;
        first_d        = 1'b0;
        cpu_stall_d    = cpu_stall_q;
        mem_read_en_d  = mem_read_en_q;
        mem_write_en_d = mem_write_en_q;
        cpu_rdata_d    = cpu_rdata_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        line_we        = 1'b0;
        word_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_write) begin
                    state_d        = ST_WR_MEM;
                    first_d        = 1'b1;
                    cpu_stall_d    = 1'b1;
                    mem_write_en_d = 1'b1;
                    mem_addr_d     = cpu_addr;
                    mem_wdata_d    = cpu_wdata;
                    if (hit) begin
                        word_we     = 1'b1;
                        hit_count_d = sat_inc(hit_count_q);
                    end else begin
                        miss_count_d = sat_inc(miss_count_q);
                    end
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata_d = rd_word;
                        hit_count_d = sat_inc(hit_count_q);
                    end else begin
                        state_d       = ST_RD_MISS;
                        first_d       = 1'b1;
                        cpu_stall_d   = 1'b1;
                        mem_read_en_d = 1'b1;
                        mem_addr_d    = {cpu_addr[AW-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        miss_count_d  = sat_inc(miss_count_q);
                    end
                end
            end
            ST_RD_MISS: begin
                if (!first_q && mem_ready) begin
                    state_d       = ST_REFILL;
                    mem_read_en_d = 1'b0;
                end
            end
            ST_REFILL: begin
                line_we     = 1'b1;
                cpu_rdata_d = mem_rdata[int'(addr_offset)*WIDTH +: WIDTH];
                cpu_stall_d = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_WR_MEM: begin
                if (!first_q && mem_ready) begin
                    state_d        = ST_IDLE;
                    mem_write_en_d = 1'b0;
                    cpu_stall_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and counters; reset aborts any transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            first_q        <= 1'b0;
            cpu_stall_q    <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            cpu_rdata_q    <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            cpu_stall_q    <= cpu_stall_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            cpu_rdata_q    <= cpu_rdata_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_stall    = cpu_stall_q;
    assign mem_addr     = mem_addr_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_wdata    = mem_wdata_q;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios followed by random traffic,
// checked against an array-based model of cache contents and main memory.
module tb_cache_controller;
    import cache_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int LINES = 32;
    localparam int AW    = 10;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [AW-1:0]               cpu_addr;
    logic                        cpu_read;
    logic                        cpu_write;
    logic [WIDTH-1:0]            cpu_wdata;
    logic [WIDTH-1:0]            cpu_rdata;
    logic                        cpu_stall;
    logic [AW-1:0]               mem_addr;
    logic                        mem_read_en;
    logic                        mem_write_en;
    logic [WIDTH-1:0]            mem_wdata;
    logic                        mem_ready;
    logic [LINE_WORDS*WIDTH-1:0] mem_rdata;
    logic [CNT_W-1:0]            hit_count;
    logic [CNT_W-1:0]            miss_count;
    state_e                      dbg_state;

    cache_controller #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LINES (LINES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: main memory, cache lines, and expected counters
    logic [WIDTH-1:0] mem_m  [DEPTH];
    bit               m_valid[LINES];
    int               m_tag  [LINES];
    logic [WIDTH-1:0] m_data [LINES][LINE_WORDS];
    int               exp_hits;
    int               exp_misses;
    logic [WIDTH-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk_counts(input string name);
        chk({name, "_hits"}, 64'(hit_count), 64'(sat(exp_hits)));
        chk({name, "_misses"}, 64'(miss_count), 64'(sat(exp_misses)));
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_stall"}, 64'(cpu_stall), 64'(0));
        chk({name, "_rd_en"}, 64'(mem_read_en), 64'(0));
        chk({name, "_wr_en"}, 64'(mem_write_en), 64'(0));
        chk({name, "_rdata"}, 64'(cpu_rdata), 64'(0));
        chk({name, "_maddr"}, 64'(mem_addr), 64'(0));
        chk({name, "_mwdata"}, 64'(mem_wdata), 64'(0));
        chk({name, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
        chk_counts(name);
    endtask

    // CPU read; d = cycles after the request edge before memory raises mem_ready
    task automatic do_read(input logic [AW-1:0] a, input int d);
        int ai, idx, tg, off, base, trans, edges;
        ai   = int'(a);
        idx  = (ai / 4) % LINES;
        tg   = ai / 128;
        off  = ai % 4;
        base = ai - off;
        cpu_addr  = a;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_hits++;
            exp_q.push_back(m_data[idx][off]);
            step();
            chk("rhit_stall", 64'(cpu_stall), 64'(0));
            chk("rhit_rd_en", 64'(mem_read_en), 64'(0));
            chk("rhit_wr_en", 64'(mem_write_en), 64'(0));
            chk("rhit_rdata", 64'(cpu_rdata), 64'(exp_q.pop_front()));
            chk_counts("rhit");
            cpu_read = 1'b0;
        end else begin
            exp_misses++;
            for (int k = 0; k < LINE_WORDS; k++) mem_rdata[k*WIDTH +: WIDTH] = mem_m[base + k];
            exp_q.push_back(mem_m[ai]);
            step();
            chk("rmiss_stall", 64'(cpu_stall), 64'(1));
            chk("rmiss_rd_en", 64'(mem_read_en), 64'(1));
            chk("rmiss_wr_en", 64'(mem_write_en), 64'(0));
            chk("rmiss_maddr", 64'(mem_addr), 64'(base));
            chk_counts("rmiss");
            trans = (d + 1 < 3) ? 3 : d + 1;
            edges = 1;
            if (edges >= d) mem_ready = 1'b1;
            while (edges < trans + 1) begin
                step();
                edges++;
                if (edges >= d) mem_ready = 1'b1;
                chk("rmiss_rd_en_wait", 64'(mem_read_en), 64'(edges < trans));
                chk("rmiss_stall_wait", 64'(cpu_stall), 64'(edges < trans + 1));
            end
            chk("rmiss_rdata", 64'(cpu_rdata), 64'(exp_q.pop_front()));
            chk("rmiss_maddr_hold", 64'(mem_addr), 64'(base));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            for (int k = 0; k < LINE_WORDS; k++) m_data[idx][k] = mem_m[base + k];
            mem_ready = 1'b0;
            cpu_read  = 1'b0;
        end
    endtask

    // CPU write (write-through, no allocate)
    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] data, input int d);
        int ai, idx, tg, off, trans, edges;
        ai  = int'(a);
        idx = (ai / 4) % LINES;
        tg  = ai / 128;
        off = ai % 4;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_hits++;
            m_data[idx][off] = data;
        end else begin
            exp_misses++;
        end
        mem_m[ai] = data;
        cpu_addr  = a;
        cpu_wdata = data;
        cpu_write = 1'b1;
        cpu_read  = 1'b0;
        step();
        chk("wr_stall", 64'(cpu_stall), 64'(1));
        chk("wr_wr_en", 64'(mem_write_en), 64'(1));
        chk("wr_rd_en", 64'(mem_read_en), 64'(0));
        chk("wr_maddr", 64'(mem_addr), 64'(ai));
        chk("wr_mwdata", 64'(mem_wdata), 64'(data));
        chk_counts("wr");
        trans = (d + 1 < 3) ? 3 : d + 1;
        edges = 1;
        if (edges >= d) mem_ready = 1'b1;
        while (edges < trans) begin
            step();
            edges++;
            if (edges >= d) mem_ready = 1'b1;
            chk("wr_wr_en_wait", 64'(mem_write_en), 64'(edges < trans));
            chk("wr_stall_wait", 64'(cpu_stall), 64'(edges < trans));
        end
        chk("wr_maddr_hold", 64'(mem_addr), 64'(ai));
        chk("wr_mwdata_hold", 64'(mem_wdata), 64'(data));
        mem_ready = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;

        reset     = 1'b0;
        cpu_addr  = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = $urandom;
        mem_m[4] = 32'hA0;
        mem_m[5] = 32'hA1;
        mem_m[6] = 32'hA2;
        mem_m[7] = 32'hA3;
        model_reset();

        step();
        step();
        chk_reset_outputs("reset");
        reset = 1'b1;
        step();

        // Cold miss with a 3-cycle memory, then a hit in the same line
        do_read(10'h004, 3);
        do_read(10'h006, 0);
        // Write hit, then read back without a memory access
        do_write(10'h005, 32'hDEAD, 2);
        do_read(10'h005, 0);
        // Write miss leaves the cache alone; the read then refills
        do_write(10'h3F0, 32'h1234, 1);
        do_read(10'h3F0, 2);
        // Conflict on index 1 evicts 0x004
        do_read(10'h084, 0);
        do_read(10'h004, 1);

        // Reset during RD_MISS aborts at once and drops all valid bits
        cpu_addr = 10'h104;
        cpu_read = 1'b1;
        step();
        chk("abort_rd_en_before", 64'(mem_read_en), 64'(1));
        step();
        reset = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("abort");
        cpu_read = 1'b0;
        step();
        reset = 1'b1;
        step();
        do_read(10'h006, 0);

        // Random traffic over a few indices so hits, misses and conflicts mix
        for (int n = 0; n < 80; n++) begin
            ra = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            rd = $urandom;
            if ($urandom_range(0, 2) == 0) do_write(ra, rd, $urandom_range(0, 4));
            else do_read(ra, $urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
